// File: rtl/song_sequencer.sv
// Song player: walks an external song ROM note by note, times each note and drives the tone generator.
// Optional macro SONG_SEQ_TEMPO_EN adds a tempo_shift input that shortens the note unit by 2^tempo_shift.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | waiting ROM_LAT cycles for the addressed note, then capturing it
// PLAY  | note sounding (or rest) for (length+1) units
// GAP   | silence between notes
module song_sequencer #(
  parameter int SONG_W      = 3,
  parameter int IDX_W       = 21,
  parameter int WHOLE_TICKS = 50_000_000,
  parameter int GAP_TICKS   = 500_000,
  parameter int ROM_LAT     = 1,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic [SONG_W-1:0] song_sel,
  output logic [SONG_W-1:0] rom_song,
  output logic [IDX_W-1:0]  rom_idx,
  input  logic [2:0]        rom_octave,
  input  logic [2:0]        rom_note,
  input  logic [3:0]        rom_length,
  input  logic [2:0]        rom_full_note,
  input  logic [IDX_W-1:0]  rom_track,
`ifdef SONG_SEQ_TEMPO_EN
  input  logic [1:0]        tempo_shift,
`endif
  output logic              tone_valid,
  output logic [2:0]        tone_octave,
  output logic [2:0]        tone_note,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  note_idx
);

  localparam int               LAT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ROM_LAT - 1);
  localparam bit               GAP_EN   = (GAP_TICKS > 0);
  localparam logic [CNT_W-1:0] GAP_INIT = CNT_W'(GAP_EN ? GAP_TICKS - 1 : 0);
  localparam logic [CNT_W-1:0] WHOLE_C  = CNT_W'(WHOLE_TICKS);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, GAP} state_t;

  state_t           state;
  logic [LAT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] unit_m1;
  logic [CNT_W-1:0] unit_cnt;
  logic [3:0]       rep_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [IDX_W-1:0] track_q;
  logic             is_rest;

  logic [3:0]       shamt;
  logic [CNT_W-1:0] shifted;
  logic [CNT_W-1:0] unit_m1_c;
  logic [IDX_W:0]   idx_inc;
  logic             last_note;
  logic             play_end;
  logic             advance;

`ifdef SONG_SEQ_TEMPO_EN
  assign shamt = {1'b0, rom_full_note} + {2'b00, tempo_shift};
`else
  assign shamt = {1'b0, rom_full_note};
`endif

  // Unit length clamps to one cycle when the shift empties the whole-note count.
  assign shifted   = WHOLE_C >> shamt;
  assign unit_m1_c = (shifted == '0) ? '0 : shifted - CNT_W'(1);

  assign idx_inc   = {1'b0, rom_idx} + (IDX_W+1)'(1);
  assign last_note = idx_inc >= {1'b0, track_q};
  assign play_end  = (unit_cnt == '0) && (rep_cnt == '0);
  assign advance   = !pause && (((state == PLAY) && play_end && !GAP_EN) ||
                                ((state == GAP) && (gap_cnt == '0)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      unit_m1     <= '0;
      unit_cnt    <= '0;
      rep_cnt     <= '0;
      gap_cnt     <= '0;
      track_q     <= '0;
      is_rest     <= 1'b0;
      rom_song    <= '0;
      rom_idx     <= '0;
      tone_valid  <= 1'b0;
      tone_octave <= '0;
      tone_note   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      note_idx    <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state       <= IDLE;
        busy        <= 1'b0;
        tone_valid  <= 1'b0;
        tone_octave <= '0;
        tone_note   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              rom_song <= song_sel;
              rom_idx  <= '0;
              lat_cnt  <= LAT_INIT;
              busy     <= 1'b1;
              state    <= FETCH;
            end
          end
          FETCH: begin
            if (lat_cnt != '0) begin
              lat_cnt <= lat_cnt - LAT_W'(1);
            end else if (rom_track == '0) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              track_q     <= rom_track;
              unit_m1     <= unit_m1_c;
              unit_cnt    <= unit_m1_c;
              rep_cnt     <= rom_length;
              is_rest     <= (rom_note == 3'd7);
              tone_valid  <= (rom_note != 3'd7);
              tone_octave <= rom_octave;
              tone_note   <= rom_note;
              note_idx    <= rom_idx;
              state       <= PLAY;
            end
          end
          PLAY: begin
            if (pause) begin
              tone_valid <= 1'b0;
            end else if (unit_cnt != '0) begin
              unit_cnt   <= unit_cnt - CNT_W'(1);
              tone_valid <= !is_rest;
            end else if (rep_cnt != '0) begin
              rep_cnt    <= rep_cnt - 4'd1;
              unit_cnt   <= unit_m1;
              tone_valid <= !is_rest;
            end else if (GAP_EN) begin
              gap_cnt    <= GAP_INIT;
              tone_valid <= 1'b0;
              state      <= GAP;
            end
          end
          GAP: begin
            if (!pause && (gap_cnt != '0)) gap_cnt <= gap_cnt - CNT_W'(1);
          end
          default: state <= IDLE;
        endcase

        // Next-note selection, shared by the end of PLAY (no gap) and the end of GAP.
        if (advance) begin
          tone_valid <= 1'b0;
          if (!last_note) begin
            rom_idx <= idx_inc[IDX_W-1:0];
            lat_cnt <= LAT_INIT;
            state   <= FETCH;
          end else if (loop) begin
            rom_idx <= '0;
            lat_cnt <= LAT_INIT;
            state   <= FETCH;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: expected per-cycle tone trace built from note durations, plus pause/stop/reset checks.
module tb_song_sequencer;
  localparam int SONG_W = 3;
  localparam int IDX_W  = 21;
  localparam int WHOLE  = 64;
  localparam int GAP    = 2;
  localparam int LAT    = 1;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, stop = 1'b0, pause = 1'b0, loop = 1'b0;
  logic [SONG_W-1:0] song_sel = '0;
  logic [SONG_W-1:0] rom_song;
  logic [IDX_W-1:0]  rom_idx;
  logic [2:0]        rom_octave, rom_note, rom_full_note;
  logic [3:0]        rom_length;
  logic [IDX_W-1:0]  rom_track;
  logic              tone_valid, busy, done;
  logic [2:0]        tone_octave, tone_note;
  logic [IDX_W-1:0]  note_idx;

  int t_oct [8][8];
  int t_note[8][8];
  int t_len [8][8];
  int t_fn  [8][8];
  int t_track[8];

  always #5 clk = ~clk;

  // ROM_LAT = 1: data settles within the cycle after the address changes.
  assign rom_octave    = 3'(t_oct [rom_song][rom_idx[2:0]]);
  assign rom_note      = 3'(t_note[rom_song][rom_idx[2:0]]);
  assign rom_length    = 4'(t_len [rom_song][rom_idx[2:0]]);
  assign rom_full_note = 3'(t_fn  [rom_song][rom_idx[2:0]]);
  assign rom_track     = IDX_W'(t_track[rom_song]);

  song_sequencer #(
    .SONG_W(SONG_W), .IDX_W(IDX_W), .WHOLE_TICKS(WHOLE), .GAP_TICKS(GAP),
    .ROM_LAT(LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .loop(loop),
    .song_sel(song_sel), .rom_song(rom_song), .rom_idx(rom_idx),
    .rom_octave(rom_octave), .rom_note(rom_note), .rom_length(rom_length),
    .rom_full_note(rom_full_note), .rom_track(rom_track),
`ifdef SONG_SEQ_TEMPO_EN
    .tempo_shift(2'b00),
`endif
    .tone_valid(tone_valid), .tone_octave(tone_octave), .tone_note(tone_note),
    .busy(busy), .done(done), .note_idx(note_idx)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    bit       play;
    bit       valid;
    bit [2:0] oct;
    bit [2:0] note;
    int       idx;
    bit       done;
    bit       busy;
  } exp_t;
  exp_t q[$];

  function automatic int dur(input int len, input int fn);
    int u;
    u = WHOLE >> fn;
    if (u < 1) u = 1;
    return (len + 1) * u;
  endfunction

  task automatic push(input bit play, input bit valid, input int oct, input int note,
                      input int idx, input bit dn, input bit bsy);
    exp_t r;
    r.play = play; r.valid = valid; r.oct = 3'(oct); r.note = 3'(note);
    r.idx = idx; r.done = dn; r.busy = bsy;
    q.push_back(r);
  endtask

  // One record per cycle after the start edge: fetch, note body, gap, ... then the done cycle.
  task automatic build(input int s, input int passes, output int pass_len);
    int d;
    pass_len = 0;
    if (t_track[s] == 0) begin
      for (int k = 0; k < LAT; k++) push(0, 0, 0, 0, 0, 0, 1);
    end else begin
      for (int p = 0; p < passes; p++) begin
        for (int i = 0; i < t_track[s]; i++) begin
          d = dur(t_len[s][i], t_fn[s][i]);
          for (int k = 0; k < LAT; k++) push(0, 0, 0, 0, 0, 0, 1);
          for (int k = 0; k < d; k++)
            push(1, t_note[s][i] != 7, t_oct[s][i], t_note[s][i], i, 0, 1);
          for (int k = 0; k < GAP; k++) push(0, 0, 0, 0, 0, 0, 1);
          if (p == 0) pass_len += LAT + d + GAP;
        end
      end
    end
    push(0, 0, 0, 0, 0, 1, 0);
  endtask

  task automatic run_trace(input int s, input int passes, input bit noise, input bit idle_pause);
    int pl;
    q.delete();
    build(s, passes, pl);
    song_sel = 3'(s);
    loop     = (passes > 1);
    start    = 1'b1;
    pause    = idle_pause;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    for (int t = 0; t < q.size(); t++) begin
      check("valid", 32'(tone_valid), 32'(q[t].valid));
      check("busy",  32'(busy),       32'(q[t].busy));
      check("done",  32'(done),       32'(q[t].done));
      if (q[t].play) begin
        check("octave",   32'(tone_octave), 32'(q[t].oct));
        check("note",     32'(tone_note),   32'(q[t].note));
        check("note_idx", 32'(note_idx),    32'(q[t].idx));
      end
      if (passes > 1 && t == pl + 1) loop = 1'b0;
      if (noise && t < q.size() - 2) begin
        start    = 1'($urandom_range(0, 1));
        song_sel = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'(0));
    check("idle_busy",      32'(busy), 32'(0));
  endtask

  task automatic start_song(input int s);
    song_sel = 3'(s);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps, pl, hi, lo, done_t, dn;

    for (int s = 0; s < 8; s++) begin
      t_track[s] = 0;
      for (int i = 0; i < 8; i++) begin
        t_oct[s][i] = 0; t_note[s][i] = 0; t_len[s][i] = 0; t_fn[s][i] = 0;
      end
    end
    // Song 0: basic two-note song.
    t_track[0] = 2;
    t_oct[0][0] = 4; t_note[0][0] = 0; t_len[0][0] = 0; t_fn[0][0] = 2;
    t_oct[0][1] = 4; t_note[0][1] = 1; t_len[0][1] = 1; t_fn[0][1] = 2;
    // Song 1: rest, then a short note.
    t_track[1] = 2;
    t_oct[1][0] = 5; t_note[1][0] = 7; t_len[1][0] = 0; t_fn[1][0] = 3;
    t_oct[1][1] = 2; t_note[1][1] = 3; t_len[1][1] = 0; t_fn[1][1] = 4;
    // Song 2: unit clamps to one cycle.
    t_track[2] = 1;
    t_oct[2][0] = 1; t_note[2][0] = 6; t_len[2][0] = 3; t_fn[2][0] = 7;
    // Song 3: empty.
    t_track[3] = 0;
    for (int s = 4; s < 8; s++) begin
      t_track[s] = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) begin
        t_oct[s][i]  = $urandom_range(0, 7);
        t_note[s][i] = $urandom_range(0, 7);
        t_len[s][i]  = $urandom_range(0, 3);
        t_fn[s][i]   = $urandom_range(2, 7);
      end
    end

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_valid",    32'(tone_valid),  32'(0));
    check("rst_busy",     32'(busy),        32'(0));
    check("rst_done",     32'(done),        32'(0));
    check("rst_rom_idx",  32'(rom_idx),     32'(0));
    check("rst_rom_song", 32'(rom_song),    32'(0));
    check("rst_note_idx", 32'(note_idx),    32'(0));

    start = 1'b1; stop = 1'b1; song_sel = 3'd4;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("start_stop_idle", 32'(busy), 32'(0));

    run_trace(0, 1, 0, 0);
    run_trace(1, 1, 0, 0);
    run_trace(2, 1, 0, 1);
    run_trace(3, 1, 0, 0);
    run_trace(0, 2, 0, 0);
    for (int s = 4; s < 8; s++) run_trace(s, 1, 1, 0);
    run_trace(4 + int'($urandom_range(0, 3)), 2, 1, 0);

    // Pause inside the first (16-cycle) note of song 0; undisturbed done lands 54 cycles after start.
    for (int r = 0; r < 3; r++) begin
      ps = $urandom_range(1, 6);
      pl = $urandom_range(1, 10);
      hi = 0; lo = 0; done_t = -1;
      start_song(0);
      for (int t = 0; t < 200 && done_t < 0; t++) begin
        if (tone_valid && note_idx == 0 && busy) hi++;
        if (t >= ps + 1 && t <= ps + pl && !tone_valid) lo++;
        if (done) done_t = t;
        pause = (t >= ps && t < ps + pl);
        @(negedge clk);
      end
      pause = 1'b0;
      check("pause_high_cycles", 32'(hi),     32'(16));
      check("pause_low_cycles",  32'(lo),     32'(pl));
      check("pause_done_time",   32'(done_t), 32'(54 + pl));
      @(negedge clk);
    end

    // Stop mid-note.
    start_song(0);
    repeat (8) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("stop_valid",  32'(tone_valid),  32'(0));
    check("stop_done",   32'(done),        32'(0));
    check("stop_busy",   32'(busy),        32'(0));
    check("stop_note",   32'(tone_note),   32'(0));
    check("stop_octave", 32'(tone_octave), 32'(0));
    dn = 0;
    repeat (70) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("stop_stays_idle", 32'(dn), 32'(0));

    // Reset during the gap after song 1's second note.
    start_song(1);
    repeat (16) @(negedge clk);
    check("pre_rst_in_gap", 32'(busy && !tone_valid && note_idx == 1), 32'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("gaprst_valid",    32'(tone_valid),  32'(0));
    check("gaprst_octave",   32'(tone_octave), 32'(0));
    check("gaprst_note",     32'(tone_note),   32'(0));
    check("gaprst_busy",     32'(busy),        32'(0));
    check("gaprst_done",     32'(done),        32'(0));
    check("gaprst_rom_idx",  32'(rom_idx),     32'(0));
    check("gaprst_rom_song", 32'(rom_song),    32'(0));
    check("gaprst_note_idx", 32'(note_idx),    32'(0));

    run_trace(0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised song player. Walks a song table note by note.
- Times each note's duration in clock cycles and drives the current tone (octave and note) to the tone generator.
- The song table is external: a ROM addressed by (song, index) returning octave, note, length, full_note and track length, with fixed read latency.
- Adds what the plain lookup lacks: start, stop, pause and loop control, a duration counter, an inter-note silence gap and end-of-song detection.

Parameters:
- SONG_W, 3, width of the song select and of rom_song.
- IDX_W, 21, width of the note index and of rom_track.
- WHOLE_TICKS, 50_000_000, clock cycles in one whole note.
- GAP_TICKS, 500_000, silent cycles between consecutive notes. 0 means no gap.
- ROM_LAT, 1, cycles from a rom_idx change until the rom_* data is valid (≥1).
- CNT_W, 32, width of the duration counters.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin playing song_sel; ignored when busy=1
- stop  in  1  abort playback; highest priority
- pause  in  1  level; freezes playback while high
- loop  in  1  level, sampled at end of song; restart at index 0
- song_sel  in  SONG_W  song to play, latched on an accepted start
- rom_song  out  SONG_W  ROM song address (latched song)
- rom_idx  out  IDX_W  ROM note index
- rom_octave  in  3  octave of the addressed note
- rom_note  in  3  0–6 = scale degree, 7 = rest
- rom_length  in  4  duration multiplier; the note lasts length+1 units
- rom_full_note  in  3  unit = WHOLE_TICKS >> full_note
- rom_track  in  IDX_W  number of notes in the song
- tone_valid  out  1  tone is sounding
- tone_octave  out  3  registered octave
- tone_note  out  3  registered note
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at natural end of song
- note_idx  out  IDX_W  index of the note currently playing

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state = IDLE.
  - All outputs are 0: rom_idx, rom_song, tone_*, busy, done, note_idx.
  - All counters clear.
- States: IDLE, FETCH, PLAY, GAP.
- IDLE:
  - start=1 latches song_sel into rom_song, sets rom_idx=0 and moves to FETCH.
  - start and stop both high: stop wins and the block stays in IDLE.
- FETCH:
  - Waits ROM_LAT cycles.
  - On the ROM_LAT-th edge it captures octave, note, length, full_note and track.
  - If captured track == 0: done pulse, go to IDLE, tone_valid never rises.
  - Otherwise go to PLAY. tone_octave/tone_note update and note_idx = rom_idx on the same edge.
- PLAY:
  - tone_valid = 1, unless note == 7 (rest), in which case tone_valid = 0 for the duration.
  - Duration D = (length+1) × max(1, WHOLE_TICKS >> full_note) cycles.
  - Implemented as a unit counter nested inside a repeat counter. No multiplier.
  - After D cycles: go to GAP if GAP_TICKS > 0, otherwise go straight to next-note selection.
- GAP:
  - tone_valid = 0 for GAP_TICKS cycles, then next-note selection.
- Next-note selection:
  - If rom_idx+1 < track: rom_idx increments, go to FETCH.
  - Else, if loop = 1: rom_idx = 0, go to FETCH. No done pulse.
  - Else: done = 1 for exactly one cycle, go to IDLE, tone_valid = 0.
- pause = 1 in PLAY or GAP:
  - All counters hold and tone_valid is forced to 0.
  - When pause drops, the remaining duration continues. Total sounding cycles still equal D.
- pause in FETCH: the fetch completes, then the pause takes effect in PLAY.
- pause in IDLE: no effect; start is still accepted.
- stop = 1 in any state: on the next edge go to IDLE, all tone outputs 0, done = 0.
- start while busy is ignored. A song_sel change mid-song has no effect.
- The rom_idx wrap at 2^IDX_W cannot occur, because track bounds the index.

Optional Feature:
- Macro: SONG_SEQ_TEMPO_EN.
- Defined:
  - Adds input port tempo_shift [1:0].
  - unit = max(1, WHOLE_TICKS >> (full_note + tempo_shift)).
  - tempo_shift is sampled at each FETCH capture. A change mid-note takes effect from the next note.
- Undefined: the port is absent and tempo_shift is treated as 0.

Test Plan:
All scenarios use WHOLE_TICKS=64, GAP_TICKS=2, ROM_LAT=1.
- Basic play:
  - Stimulus: song 0 = 2 notes {oct4, note0, len0, fn2} and {oct4, note1, len1, fn2}, track=2, start pulse.
  - Response: tone_valid high for 16 cycles with note0, low 2 cycles, high 32 cycles with note1, low 2 cycles, then a done pulse and busy falls.
- Rest note:
  - Stimulus: note=7, len=0, fn=3.
  - Response: tone_valid stays 0 for 8 cycles; note_idx advances as normal.
- Pause:
  - Stimulus: pause high for 10 cycles, starting 5 cycles into a 16-cycle note.
  - Response: tone_valid low during the pause; total high cycles for the note = 16; completion delayed by exactly 10 cycles.
- Loop:
  - Stimulus: loop=1 with a 2-note song.
  - Response: after note 1, rom_idx returns to 0 and no done pulse occurs. Deasserting loop ends the song after the next pass with a single done pulse.
- Stop and reset:
  - Stimulus: stop mid-PLAY.
  - Response: the next cycle is IDLE with tone_valid = 0 and done = 0.
  - Stimulus: rst_n low mid-GAP.
  - Response: all outputs 0 on the next edge.
- Edge cases:
  - Stimulus: track = 0.
  - Response: done pulse ROM_LAT+1 cycles after start, tone_valid never high.
  - Stimulus: fn = 7 (64 >> 7 = 0).
  - Response: unit clamps to 1, so len=3 lasts 4 cycles.
